wb_copy_master: RTL and testbench

Wishbone classic-cycle bus master that moves blocks of 32-bit words between slaves on the SOPC bus (e.g. on-chip RAM to RAM, or RAM to peripheral). It also fills a region with a constant word. It is the initiator counterpart of the single-cycle-ack RAM slave. The CPU or a control register bank programs it through a simple start/len/address port. It then runs read-then-write word transfers until the count is exhausted, an error is reported, or a watchdog expires.

---
 rtl/wb_copy_master.sv | 193 +++++++++++++++++++
 tb/tb_wb_copy_master.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_copy_master.sv
// Wishbone classic-cycle block copy / fill master.
// Runs read-then-write word transfers (copy) or write-only transfers (fill)
// until the word count is exhausted, the slave reports an error, or the
// per-access ack watchdog expires.
module wb_copy_master #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             fill_i,
    input  logic [31:0]      src_adr_i,
    input  logic [31:0]      dst_adr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      fill_dat_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [31:0]      wb_adr_o,
    output logic [3:0]       wb_sel_o,
    output logic [31:0]      wb_dat_o,
    input  logic [31:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_err_i
);

    localparam int unsigned WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [31:0] ADR_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               fill_q, fill_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;

    logic               cyc_d, stb_d, we_d, busy_d, done_d, err_d;
    logic [31:0]        adr_d, dat_d;
    logic [3:0]         sel_d;

    logic               timeout_c;
    logic [31:0]        src_nxt_c, dst_nxt_c;

    assign timeout_c = (wait_q == WAIT_W'(TIMEOUT - 1));
    assign src_nxt_c = src_q + 32'd4;
    assign dst_nxt_c = dst_q + 32'd4;

    // Next-state and next-output computation for all registered outputs
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        wait_d  = wait_q;
        cyc_d   = wb_cyc_o;
        stb_d   = wb_stb_o;
        we_d    = wb_we_o;
        adr_d   = wb_adr_o;
        sel_d   = wb_sel_o;
        dat_d   = wb_dat_o;
        busy_d  = busy_o;
        done_d  = 1'b0;
        err_d   = err_o;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    err_d = 1'b0;
                    if (len_i != '0) begin
                        src_d  = src_adr_i & ADR_MASK;
                        dst_d  = dst_adr_i & ADR_MASK;
                        cnt_d  = len_i;
                        fill_d = fill_i;
                        wait_d = '0;
                        cyc_d  = 1'b1;
                        stb_d  = 1'b1;
                        sel_d  = 4'hF;
                        busy_d = 1'b1;
                        if (fill_i) begin
                            state_d = WR;
                            we_d    = 1'b1;
                            adr_d   = dst_adr_i & ADR_MASK;
                            dat_d   = fill_dat_i;
                        end else begin
                            state_d = RD;
                            we_d    = 1'b0;
                            adr_d   = src_adr_i & ADR_MASK;
                        end
                    end else begin
                        // Zero-length request: just report completion
                        state_d = FIN;
                        done_d  = 1'b1;
                    end
                end
            end

            RD, WR: begin
                if (wb_err_i || (!wb_ack_i && timeout_c)) begin
                    state_d = FIN;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = 4'h0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    wait_d = '0;
                    if (state_q == RD) begin
                        state_d = WR;
                        dat_d   = wb_dat_i;
                        we_d    = 1'b1;
                        adr_d   = dst_q;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                        src_d = src_nxt_c;
                        dst_d = dst_nxt_c;
                        if (cnt_q == LEN_W'(1)) begin
                            state_d = FIN;
                            cyc_d   = 1'b0;
                            stb_d   = 1'b0;
                            we_d    = 1'b0;
                            sel_d   = 4'h0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else if (fill_q) begin
                            adr_d = dst_nxt_c;
                        end else begin
                            state_d = RD;
                            we_d    = 1'b0;
                            adr_d   = src_nxt_c;
                        end
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            fill_q   <= 1'b0;
            wait_q   <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_sel_o <= '0;
            wb_dat_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            fill_q   <= fill_d;
            wait_q   <= wait_d;
            wb_cyc_o <= cyc_d;
            wb_stb_o <= stb_d;
            wb_we_o  <= we_d;
            wb_adr_o <= adr_d;
            wb_sel_o <= sel_d;
            wb_dat_o <= dat_d;
            busy_o   <= busy_d;
            done_o   <= done_d;
            err_o    <= err_d;
        end
    end

endmodule

// File: tb/tb_wb_copy_master.sv
// Self-checking bench for wb_copy_master: directed scenarios plus randomized
// copy/fill transfers against a Wishbone RAM slave with random ack latency.
module tb_wb_copy_master;

    localparam int unsigned LEN_W     = 16;
    localparam int unsigned TIMEOUT   = 255;
    localparam int unsigned MEM_WORDS = 1024;

    logic             clk = 1'b0;
    logic             rst_i, start_i, fill_i;
    logic [31:0]      src_adr_i, dst_adr_i, fill_dat_i;
    logic [LEN_W-1:0] len_i;
    logic             busy_o, done_o, err_o;
    logic             wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0]      wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]       wb_sel_o;
    logic             wb_ack_i, wb_err_i;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;

    // Slave configuration (written by the main sequence while idle)
    int unsigned max_wait = 0;
    bit          fast = 1'b0;
    bit          stuck = 1'b0;
    int          err_at = -1;
    bit          clr_req = 1'b0;

    // Slave memory: preload image plus a written-word overlay
    logic [31:0] init_mem [MEM_WORDS];
    logic [31:0] wmem     [MEM_WORDS];
    bit          wvalid   [MEM_WORDS];

    logic        ack_r, err_r;
    logic [31:0] rd_r;
    int unsigned wait_left;
    int          acc_idx;

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
    } acc_t;
    acc_t exp_q[$];

    wb_copy_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .fill_i(fill_i),
        .src_adr_i(src_adr_i), .dst_adr_i(dst_adr_i), .len_i(len_i),
        .fill_dat_i(fill_dat_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] rdm(input int unsigned idx);
        return wvalid[idx] ? wmem[idx] : init_mem[idx];
    endfunction

    function automatic int unsigned widx(input logic [31:0] adr);
        return int'(adr[11:2]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    assign wb_ack_i = fast ? (wb_cyc_o & wb_stb_o) : ack_r;
    assign wb_err_i = fast ? 1'b0 : err_r;
    assign wb_dat_i = fast ? rdm(widx(wb_adr_o)) : rd_r;

    // Wishbone RAM slave: registered ack after a random wait, one idle cycle after each ack
    always @(posedge clk) begin
        if (clr_req) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) wvalid[i] <= 1'b0;
        end
        if (rst_i) begin
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            rd_r      <= '0;
            wait_left <= 0;
            acc_idx   <= 0;
        end else if (fast) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
            if (wb_cyc_o && wb_stb_o && wb_we_o) begin
                wmem[widx(wb_adr_o)]   <= wb_dat_o;
                wvalid[widx(wb_adr_o)] <= 1'b1;
            end
        end else if (ack_r || err_r) begin
            ack_r     <= 1'b0;
            err_r     <= 1'b0;
            wait_left <= $urandom_range(max_wait);
        end else if (!(wb_cyc_o && wb_stb_o)) begin
            wait_left <= $urandom_range(max_wait);
            acc_idx   <= 0;
        end else if (stuck) begin
            ack_r <= 1'b0;
        end else if (wait_left != 0) begin
            wait_left <= wait_left - 1;
        end else if (acc_idx == err_at) begin
            err_r   <= 1'b1;
            acc_idx <= acc_idx + 1;
        end else begin
            ack_r   <= 1'b1;
            acc_idx <= acc_idx + 1;
            if (wb_we_o) begin
                wmem[widx(wb_adr_o)]   <= wb_dat_o;
                wvalid[widx(wb_adr_o)] <= 1'b1;
            end else begin
                rd_r <= rdm(widx(wb_adr_o));
            end
        end
    end

    // Per-cycle compare: bus control invariants and every acked access against the expected list
    bit done_prev = 1'b0;
    always @(negedge clk) begin
        acc_t e;
        if (!rst_i) begin
            chk("bus_ctl", 32'({wb_stb_o, wb_sel_o, wb_adr_o[1:0], busy_o, done_o & done_prev}),
                32'({wb_cyc_o, wb_cyc_o ? 4'hF : 4'h0, 2'b00, wb_cyc_o, 1'b0}));
            if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_err_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_access", wb_adr_o, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("acc_we", 32'(wb_we_o), 32'(e.we));
                    chk("acc_adr", wb_adr_o, e.adr);
                    if (e.we) chk("acc_dat", wb_dat_o, e.dat);
                end
            end
        end
        done_prev = done_o;
    end

    task automatic do_start(input bit f, input logic [31:0] s, input logic [31:0] d,
                            input int l, input logic [31:0] p, output int n);
        @(negedge clk);
        fill_i = f; src_adr_i = s; dst_adr_i = d; len_i = LEN_W'(l);
        fill_dat_i = p; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        n = cyc_cnt;
    endtask

    task automatic wait_done(input int budget, output int de, output bit b, output bit c,
                             output bit r);
        b = 0; c = 0; r = 0; de = -1;
        for (int i = 0; i < budget; i++) begin
            if (busy_o) b = 1;
            if (wb_cyc_o) c = 1;
            if (wb_cyc_o && !wb_we_o) r = 1;
            if (done_o) begin
                de = cyc_cnt;
                break;
            end
            @(negedge clk);
        end
        if (de < 0) chk("done_timeout", 32'(0), 32'(1));
    endtask

    task automatic push_xfer(input bit f, input logic [31:0] s, input logic [31:0] d,
                             input int l, input logic [31:0] p);
        acc_t e;
        for (int i = 0; i < l; i++) begin
            if (!f) begin
                e.we = 1'b0; e.adr = s + 32'(4 * i); e.dat = '0;
                exp_q.push_back(e);
            end
            e.we  = 1'b1;
            e.adr = d + 32'(4 * i);
            e.dat = f ? p : init_mem[widx(s) + 32'(i)];
            exp_q.push_back(e);
        end
    endtask

    task automatic reload_mem();
        for (int i = 0; i < int'(MEM_WORDS); i++) init_mem[i] = $urandom;
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
    endtask

    initial begin
        int n, de;
        bit b, c, r, f, seen_done;
        int l;
        logic [31:0] s, d, p;
        logic [31:0] pat [4];

        rst_i = 1'b1; start_i = 1'b0; fill_i = 1'b0; src_adr_i = '0; dst_adr_i = '0;
        len_i = '0; fill_dat_i = '0;
        for (int i = 0; i < int'(MEM_WORDS); i++) begin
            init_mem[i] = '0; wmem[i] = '0; wvalid[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        // Reset state held through 10 idle cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_ctl", 32'({busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'(0));
            chk("reset_adr", wb_adr_o, 32'(0));
            chk("reset_dat", wb_dat_o, 32'(0));
        end

        // Directed copy of 4 words, RAM slave
        reload_mem();
        pat[0] = 32'h1111_1111; pat[1] = 32'h2222_2222; pat[2] = 32'h3333_3333; pat[3] = 32'h4444_4444;
        for (int i = 0; i < 4; i++) init_mem[i] = pat[i];
        push_xfer(1'b0, 32'h000, 32'h100, 4, 32'h0);
        do_start(1'b0, 32'h000, 32'h100, 4, 32'h0, n);
        wait_done(100, de, b, c, r);
        chk("copy4_done_edge", 32'(de - n), 32'd16);
        chk("copy4_err", 32'(err_o), 32'(0));
        for (int i = 0; i < 4; i++) chk("copy4_mem", rdm(32'h40 + 32'(i)), pat[i]);
        chk("copy4_q_empty", 32'(exp_q.size()), 32'(0));

        // Directed fill of 3 words
        push_xfer(1'b1, 32'h0, 32'h200, 3, 32'hDEAD_BEEF);
        do_start(1'b1, 32'h0, 32'h200, 3, 32'hDEAD_BEEF, n);
        wait_done(100, de, b, c, r);
        chk("fill3_done_edge", 32'(de - n), 32'd6);
        chk("fill3_no_read", 32'(r), 32'(0));
        for (int i = 0; i < 3; i++) chk("fill3_mem", rdm(32'h80 + 32'(i)), 32'hDEAD_BEEF);
        chk("fill3_q_empty", 32'(exp_q.size()), 32'(0));

        // Slave error on the 3rd access of an 8-word copy
        reload_mem();
        err_at = 2;
        push_xfer(1'b0, 32'h040, 32'h300, 1, 32'h0);
        do_start(1'b0, 32'h040, 32'h300, 8, 32'h0, n);
        wait_done(100, de, b, c, r);
        chk("err_done_edge", 32'(de - n), 32'd6);
        chk("err_flag", 32'(err_o), 32'(1));
        chk("err_word0", rdm(32'hC0), init_mem[32'h10]);
        chk("err_word1_untouched", 32'(wvalid[32'hC1]), 32'(0));
        repeat (5) @(negedge clk);
        chk("err_held", 32'(err_o), 32'(1));
        chk("err_q_empty", 32'(exp_q.size()), 32'(0));
        err_at = -1;

        // Stuck slave: watchdog abort
        stuck = 1'b1;
        do_start(1'b0, 32'h000, 32'h100, 2, 32'h0, n);
        wait_done(TIMEOUT + 20, de, b, c, r);
        chk("timeout_done_edge", 32'(de - n), 32'(TIMEOUT));
        chk("timeout_err", 32'(err_o), 32'(1));
        stuck = 1'b0;
        @(negedge clk);

        // Zero-length start clears err, no bus activity
        do_start(1'b0, 32'h000, 32'h100, 0, 32'h0, n);
        wait_done(20, de, b, c, r);
        chk("len0_done_edge", 32'(de - n), 32'd0);
        chk("len0_err_cleared", 32'(err_o), 32'(0));
        chk("len0_busy_cyc", 32'({b, c}), 32'(0));

        // Start while busy is ignored
        reload_mem();
        push_xfer(1'b0, 32'h020, 32'h140, 4, 32'h0);
        do_start(1'b0, 32'h020, 32'h140, 4, 32'h0, n);
        repeat (4) @(negedge clk);
        fill_i = 1'b1; dst_adr_i = 32'h3F0; len_i = LEN_W'(1); fill_dat_i = 32'hCAFE_F00D;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(100, de, b, c, r);
        chk("busy_start_done_edge", 32'(de - n), 32'd16);
        for (int i = 0; i < 4; i++) chk("busy_start_mem", rdm(32'h50 + 32'(i)), init_mem[8 + i]);
        chk("busy_start_untouched", 32'(wvalid[32'hFC]), 32'(0));
        chk("busy_start_q_empty", 32'(exp_q.size()), 32'(0));

        // Reset in the middle of a copy (after two words)
        reload_mem();
        push_xfer(1'b0, 32'h030, 32'h180, 4, 32'h0);
        do_start(1'b0, 32'h030, 32'h180, 4, 32'h0, n);
        while (cyc_cnt < n + 9) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        chk("midrst_ctl", 32'({busy_o, done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}), 32'(0));
        chk("midrst_adr", wb_adr_o, 32'(0));
        seen_done = 1'b0; c = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
            if (wb_cyc_o) c = 1'b1;
        end
        chk("midrst_quiet", 32'({seen_done, c}), 32'(0));
        chk("midrst_word0", rdm(32'h60), init_mem[12]);
        chk("midrst_word1", rdm(32'h61), init_mem[13]);
        chk("midrst_word2_untouched", 32'(wvalid[32'h62]), 32'(0));

        // Randomized copy/fill transfers with random slave latency
        for (int t = 0; t < 24; t++) begin
            reload_mem();
            f        = 1'($urandom_range(1));
            l        = int'($urandom_range(8, 1));
            s        = 32'($urandom_range(200)) << 2;
            d        = (32'd512 + 32'($urandom_range(200))) << 2;
            p        = $urandom;
            fast     = ($urandom_range(3) == 0);
            max_wait = $urandom_range(3);
            @(negedge clk);
            push_xfer(f, s, d, l, p);
            do_start(f, s | 32'($urandom_range(3)), d | 32'($urandom_range(3)), l, p, n);
            wait_done(l * 2 * (int'(max_wait) + 3) + 20, de, b, c, r);
            if (fast) chk("rnd_fast_done_edge", 32'(de - n), 32'((f ? 1 : 2) * l));
            else if (max_wait == 0) chk("rnd_ram_done_edge", 32'(de - n), 32'((f ? 2 : 4) * l));
            chk("rnd_err", 32'(err_o), 32'(0));
            for (int i = 0; i < l; i++)
                chk("rnd_mem", rdm(widx(d) + 32'(i)), f ? p : init_mem[widx(s) + 32'(i)]);
            chk("rnd_beyond_untouched", 32'(wvalid[widx(d) + 32'(l)]), 32'(0));
            chk("rnd_q_empty", 32'(exp_q.size()), 32'(0));
            exp_q.delete();
        end
        fast = 1'b0;
        max_wait = 0;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
